// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM.
// Optional MEMCTRL_IO_STALL_EN adds io_full_i and holds store bytes aimed at the IO region.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_busy_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
`ifdef MEMCTRL_IO_STALL_EN
    ,
    input  logic              io_full_i
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  n;
    logic        is_mem;
    logic [23:0] wbuf;
    logic [31:0] rbuf;
    logic [31:0] rnext;
    logic [1:0]  lane;
    logic        hold_grant;
    logic        hold_cur;
    logic        hold_next;

    assign mem_busy_o = mem_req_i & ~mem_done_o;

`ifdef MEMCTRL_IO_STALL_EN
    assign hold_grant = io_full_i && (mem_addr_i >= IO_BASE);
    assign hold_cur   = io_full_i && (ram_a_o >= IO_BASE);
    assign hold_next  = io_full_i && ((ram_a_o + ADDR_W'(1)) >= IO_BASE);
`else
    logic unused_io_base;
    assign unused_io_base = ^IO_BASE;
    assign hold_grant = 1'b0;
    assign hold_cur   = 1'b0;
    assign hold_next  = 1'b0;
`endif

    // cnt is one ahead of the lane being captured: RAM data lags its address by a cycle.
    assign lane = cnt[1:0] - 2'd1;

    always_comb begin
        rnext = rbuf;
        rnext[{lane, 3'b000} +: 8] = ram_din_i;
    end

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            n           <= '0;
            is_mem      <= 1'b0;
            wbuf        <= '0;
            rbuf        <= '0;
            ram_a_o     <= '0;
            ram_wr_o    <= 1'b0;
            ram_dout_o  <= '0;
            if_done_o   <= 1'b0;
            if_inst_o   <= '0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    ram_wr_o <= 1'b0;
                    cnt      <= '0;
                    rbuf     <= '0;
                    if (mem_req_i) begin
                        is_mem     <= 1'b1;
                        ram_a_o    <= mem_addr_i;
                        n          <= size_to_n(mem_size_i);
                        wbuf       <= mem_wdata_i[31:8];
                        ram_dout_o <= mem_wdata_i[7:0];
                        if (mem_we_i) begin
                            ram_wr_o <= !hold_grant;
                            state    <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end else if (if_req_i) begin
                        is_mem  <= 1'b0;
                        ram_a_o <= if_addr_i;
                        n       <= 3'd4;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (!is_mem && if_abort_i) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0) rbuf <= rnext;
                        if (cnt == n) begin
                            state <= DONE;
                            if (is_mem) begin
                                mem_done_o  <= 1'b1;
                                mem_rdata_o <= rnext;
                            end else begin
                                if_done_o <= 1'b1;
                                if_inst_o <= rnext;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt + 3'd1 < n) ram_a_o <= ram_a_o + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // A low strobe inside WRITE means the current byte is held for the IO buffer.
                    if (!ram_wr_o) begin
                        if (!hold_cur) ram_wr_o <= 1'b1;
                    end else if (cnt == n - 3'd1) begin
                        state      <= DONE;
                        ram_wr_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                    end else begin
                        cnt        <= cnt + 3'd1;
                        ram_a_o    <= ram_a_o + ADDR_W'(1);
                        ram_dout_o <= wbuf[7:0];
                        wbuf       <= {8'h00, wbuf[23:8]};
                        ram_wr_o   <= !hold_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
